// File: rtl/fb_pkg.sv
// Shared constants, burst FSM state type and frame geometry helpers for the
// frame-buffer writer.
package fb_pkg;

   localparam int PIX_W = 16;
   localparam int MEM_W = 128;
   localparam int LANES = MEM_W / PIX_W;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DATA,
      DONE
   } fb_state_t;

   function automatic int frame_words(input int h_disp, input int v_disp);
      return (h_disp * v_disp) / LANES;
   endfunction

   function automatic int burst_bytes(input int burst);
      return (burst * MEM_W) / 8;
   endfunction

endpackage

// File: rtl/fb_fifo.sv
// Synchronous packed-word FIFO with a registered read port (data one cycle
// after pop), occupancy count and a flush that empties it in one cycle.
module fb_fifo #(
   parameter int DEPTH = 128,
   parameter int W     = 128
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [W-1:0]             push_data,
   input  logic                     pop,
   output logic [W-1:0]             pop_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // pop_data is left untouched by flush so a beat already on the bus stays put.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         pop_data <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop) begin
            rd_ptr   <= rd_ptr + AW'(1);
            pop_data <= mem[rd_ptr];
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fb_writer.sv
// Packs aligned RGB565 pixels into 128-bit words and writes each frame to one
// of two memory buffers as fixed-length bursts, flipping buffers per frame.
module fb_writer
   import fb_pkg::*;
#(
   parameter int                H_DISP     = 1280,
   parameter int                V_DISP     = 720,
   parameter int                BURST      = 64,
   parameter int                FIFO_DEPTH = 128,
   parameter int                ADDR_W     = 28,
   parameter logic [ADDR_W-1:0] BASE0      = '0,
   parameter logic [ADDR_W-1:0] BASE1      = ADDR_W'(32'h0200000)
) (
   input  logic              video_clk,
   input  logic              rst,
   input  logic [15:0]       data_aligned,
   input  logic              data_aligned_valid,
   input  logic              data_aligned_vs,
   output logic              wr_req,
   input  logic              wr_ack,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [127:0]      wr_data,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic              wr_last,
   output logic              disp_buf,
   output logic              frame_done,
   output logic              overflow,
   output logic              short_frame
);

   localparam int FRAME_WORDS  = frame_words(H_DISP, V_DISP);
   localparam int FRAME_BURSTS = FRAME_WORDS / BURST;
   localparam int BURST_BYTES  = burst_bytes(BURST);
   localparam int WC_W         = $clog2(FRAME_WORDS + 1);
   localparam int BC_W         = $clog2(FRAME_BURSTS + 1);
   localparam int BT_W         = $clog2(BURST + 1);
   localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1;
   localparam int LANE_W       = $clog2(LANES);
   localparam logic [BT_W-1:0]   LAST_BEAT = BT_W'(BURST - 1);
   localparam logic [ADDR_W-1:0] BB_STEP   = ADDR_W'(BURST_BYTES);

   logic              vs_q;
   logic              started;
   logic              sof;
   logic              abort;
   logic              pix_take;
   logic [LANE_W-1:0] lane;
   logic [MEM_W-1:0]  pack;
   logic              push_q;
   logic [MEM_W-1:0]  push_word;
   logic [WC_W-1:0]   word_cnt;

   logic              fifo_push;
   logic              fifo_pop;
   logic              pop_req;
   logic [MEM_W-1:0]  fifo_q;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_full;
   logic              fifo_empty;

   fb_state_t         state;
   fb_state_t         state_nx;
   logic [BT_W-1:0]   beat_cnt;
   logic [BC_W-1:0]   burst_cnt;
   logic              abort_pend;
   logic              wr_buf;
   logic              hs;
   logic [ADDR_W-1:0] burst_addr;

   assign sof = data_aligned_vs && !vs_q;
   // A restart only counts as short if this frame produced words but never finished.
   assign abort = sof && (word_cnt != '0) && (burst_cnt != BC_W'(FRAME_BURSTS));
   assign pix_take = data_aligned_valid && started && !sof &&
                     (word_cnt != WC_W'(FRAME_WORDS));
   assign fifo_push = push_q && !sof;

   always_ff @(posedge video_clk) begin
      if (rst) begin
         vs_q        <= 1'b0;
         started     <= 1'b0;
         lane        <= '0;
         pack        <= '0;
         push_q      <= 1'b0;
         push_word   <= '0;
         word_cnt    <= '0;
         overflow    <= 1'b0;
         short_frame <= 1'b0;
      end else begin
         vs_q   <= data_aligned_vs;
         push_q <= 1'b0;
         if (sof) begin
            started  <= 1'b1;
            lane     <= '0;
            word_cnt <= '0;
         end else if (pix_take) begin
            if (lane == LANE_W'(LANES - 1)) begin
               push_q    <= 1'b1;
               push_word <= {data_aligned, pack[MEM_W-PIX_W-1:0]};
               word_cnt  <= word_cnt + WC_W'(1);
               lane      <= '0;
            end else begin
               pack[int'(lane)*PIX_W +: PIX_W] <= data_aligned;
               lane <= lane + LANE_W'(1);
            end
         end
         if (fifo_push && fifo_full) overflow <= 1'b1;
         if (abort) short_frame <= 1'b1;
      end
   end

   fb_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (MEM_W)
   ) u_fifo (
      .clk       (video_clk),
      .rst       (rst),
      .flush     (abort),
      .push      (fifo_push),
      .push_data (push_word),
      .pop       (fifo_pop),
      .pop_data  (fifo_q),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign hs       = wr_valid && wr_ready;
   assign fifo_pop = pop_req && !fifo_empty;

   // The first beat is fetched on the ack so it is on the bus the cycle DATA starts;
   // each handshake fetches the next beat so wr_valid stays up across the burst.
   always_comb begin
      state_nx = state;
      pop_req  = 1'b0;
      case (state)
         IDLE: begin
            if (!sof && (fifo_count >= CNT_W'(BURST)) &&
                (burst_cnt < BC_W'(FRAME_BURSTS)))
               state_nx = REQ;
         end
         REQ: begin
            if (abort) begin
               state_nx = IDLE;
            end else if (wr_ack) begin
               state_nx = DATA;
               pop_req  = 1'b1;
            end
         end
         DATA: begin
            if (hs) begin
               if (abort || abort_pend)
                  state_nx = IDLE;
               else if (beat_cnt == LAST_BEAT)
                  state_nx = (burst_cnt == BC_W'(FRAME_BURSTS - 1)) ? DONE : IDLE;
               else
                  pop_req = 1'b1;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge video_clk) begin
      if (rst) begin
         state      <= IDLE;
         beat_cnt   <= '0;
         burst_cnt  <= '0;
         abort_pend <= 1'b0;
         wr_buf     <= 1'b0;
         disp_buf   <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == REQ)
            beat_cnt <= '0;
         else if (hs)
            beat_cnt <= beat_cnt + BT_W'(1);
         if (sof)
            burst_cnt <= '0;
         else if (hs && (beat_cnt == LAST_BEAT) && !abort_pend)
            burst_cnt <= burst_cnt + BC_W'(1);
         abort_pend <= (state == DATA) && (state_nx == DATA) && (abort_pend || abort);
         if (state == DONE) begin
            disp_buf <= wr_buf;
            wr_buf   <= !wr_buf;
         end
      end
   end

   assign burst_addr = (wr_buf ? BASE1 : BASE0) + ADDR_W'(burst_cnt) * BB_STEP;

   assign wr_req     = (state == REQ);
   assign wr_addr    = wr_req ? burst_addr : '0;
   assign wr_valid   = (state == DATA);
   assign wr_data    = wr_valid ? fifo_q : '0;
   assign wr_last    = wr_valid && (beat_cnt == LAST_BEAT);
   assign frame_done = (state == DONE);

endmodule

// File: tb/tb_fb_writer.sv
// Directed bench for fb_writer on a 16x4 frame with 2-beat bursts and a
// 4-deep FIFO; a responder plays the memory controller and scores every beat.
module tb_fb_writer;

   localparam int          ADDR_W = 28;
   localparam logic [27:0] BASE0  = 28'h0000000;
   localparam logic [27:0] BASE1  = 28'h0200000;

   logic          video_clk = 1'b0;
   logic          rst = 1'b1;
   logic [15:0]   data_aligned = '0;
   logic          data_aligned_valid = 1'b0;
   logic          data_aligned_vs = 1'b0;
   logic          wr_req;
   logic          wr_ack = 1'b0;
   logic [27:0]   wr_addr;
   logic [127:0]  wr_data;
   logic          wr_valid;
   logic          wr_ready = 1'b0;
   logic          wr_last;
   logic          disp_buf;
   logic          frame_done;
   logic          overflow;
   logic          short_frame;

   int            n_vec = 0;
   int            n_bad = 0;
   logic [127:0]  exp_q[$];
   logic [27:0]   exp_addr_q[$];
   int            fd_count = 0;
   int            req_age = 0;
   int            beat_idx = 0;
   logic          ack_block = 1'b0;
   logic          ready_mode = 1'b0;
   logic          tog = 1'b1;
   logic [27:0]   exp_a;
   logic [127:0]  exp_d;

   always #5 video_clk = ~video_clk;

   fb_writer #(
      .H_DISP     (16),
      .V_DISP     (4),
      .BURST      (2),
      .FIFO_DEPTH (4),
      .ADDR_W     (ADDR_W),
      .BASE0      (BASE0),
      .BASE1      (BASE1)
   ) dut (
      .video_clk          (video_clk),
      .rst                (rst),
      .data_aligned       (data_aligned),
      .data_aligned_valid (data_aligned_valid),
      .data_aligned_vs    (data_aligned_vs),
      .wr_req             (wr_req),
      .wr_ack             (wr_ack),
      .wr_addr            (wr_addr),
      .wr_data            (wr_data),
      .wr_valid           (wr_valid),
      .wr_ready           (wr_ready),
      .wr_last            (wr_last),
      .disp_buf           (disp_buf),
      .frame_done         (frame_done),
      .overflow           (overflow),
      .short_frame        (short_frame)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Memory-controller responder and scoreboard; everything sampled on negedge.
   initial begin
      forever begin
         @(negedge video_clk);
         req_age = wr_req ? req_age + 1 : 0;
         wr_ack  = wr_req && !ack_block && (req_age >= 3);
         if (ready_mode) begin
            wr_ready = tog;
            if (wr_valid) tog = ~tog;
         end else begin
            wr_ready = 1'b1;
         end
         if (frame_done) fd_count++;
         if (wr_req || wr_valid) check("req_valid_excl", 128'(wr_req & wr_valid), 128'd0);
         if (wr_req) begin
            exp_a = (exp_addr_q.size() > 0) ? exp_addr_q[0] : ~wr_addr;
            check("wr_addr", 128'(wr_addr), 128'(exp_a));
            if (wr_ack && exp_addr_q.size() > 0) exp_addr_q.delete(0);
         end
         if (wr_valid) begin
            exp_d = (exp_q.size() > 0) ? exp_q[0] : ~wr_data;
            check("wr_data", wr_data, exp_d);
            check("wr_last", 128'(wr_last), 128'(beat_idx == 1));
            if (wr_ready) begin
               if (exp_q.size() > 0) exp_q.delete(0);
               beat_idx = (beat_idx + 1) % 2;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      @(negedge video_clk);
      rst = 1'b1;
      data_aligned_valid = 1'b0;
      data_aligned_vs = 1'b0;
      data_aligned = '0;
      repeat (3) @(negedge video_clk);
      check("rst_wr_req", 128'(wr_req), 128'd0);
      check("rst_wr_valid", 128'(wr_valid), 128'd0);
      check("rst_wr_last", 128'(wr_last), 128'd0);
      check("rst_wr_addr", 128'(wr_addr), 128'd0);
      check("rst_wr_data", wr_data, 128'd0);
      check("rst_disp_buf", 128'(disp_buf), 128'd0);
      check("rst_frame_done", 128'(frame_done), 128'd0);
      check("rst_overflow", 128'(overflow), 128'd0);
      check("rst_short_frame", 128'(short_frame), 128'd0);
      exp_q.delete();
      exp_addr_q.delete();
      fd_count   = 0;
      ack_block  = 1'b0;
      ready_mode = 1'b0;
      tog        = 1'b1;
      beat_idx   = 0;
      rst = 1'b0;
      @(negedge video_clk);
   endtask

   task automatic push_words(input logic [15:0] base, input int k0, input int k1);
      logic [127:0] w;
      for (int k = k0; k < k1; k++) begin
         for (int j = 0; j < 8; j++) w[j*16 +: 16] = base + 16'(8*k + j);
         exp_q.push_back(w);
      end
   endtask

   task automatic push_addrs(input logic [27:0] base, input int n);
      for (int b = 0; b < n; b++) exp_addr_q.push_back(base + 28'(b * 32));
   endtask

   task automatic send_frame(input logic [15:0] base, input int n, input int rel, input bit with_sof);
      if (with_sof) begin
         data_aligned_vs = 1'b1;
         @(negedge video_clk);
         data_aligned_vs = 1'b0;
      end
      for (int i = 0; i < n; i++) begin
         if (i == rel) ack_block = 1'b0;
         data_aligned_valid = 1'b1;
         data_aligned = base + 16'(i);
         @(negedge video_clk);
      end
      data_aligned_valid = 1'b0;
      repeat (2) @(negedge video_clk);
   endtask

   task automatic wait_fd(input int target, input int budget);
      int t = 0;
      while (fd_count < target && t < budget) begin
         @(negedge video_clk);
         t++;
      end
      repeat (4) @(negedge video_clk);
      check("frame_done_cnt", 128'(fd_count), 128'(target));
   endtask

   task automatic wait_idle(input int budget);
      int t = 0;
      while ((exp_q.size() != 0 || exp_addr_q.size() != 0) && t < budget) begin
         @(negedge video_clk);
         t++;
      end
      check("beats_pending", 128'(exp_q.size()), 128'd0);
      check("bursts_pending", 128'(exp_addr_q.size()), 128'd0);
   endtask

   initial begin
      do_reset();

      // Two back-to-back frames; stray pixels before the first sof must vanish.
      send_frame(16'hAAAA, 16, -1, 1'b0);
      exp_q.push_back(128'h0007_0006_0005_0004_0003_0002_0001_0000);
      push_words(16'h0000, 1, 8);
      push_addrs(BASE0, 4);
      send_frame(16'h0000, 64, -1, 1'b1);
      wait_fd(1, 300);
      wait_idle(100);
      check("disp_buf_f1", 128'(disp_buf), 128'd0);
      push_words(16'h0100, 0, 8);
      push_addrs(BASE1, 4);
      send_frame(16'h0100, 64, -1, 1'b1);
      wait_fd(2, 300);
      wait_idle(100);
      repeat (10) @(negedge video_clk);
      check("frame_done_twice", 128'(fd_count), 128'd2);
      check("disp_buf_f2", 128'(disp_buf), 128'd1);
      check("overflow_f2", 128'(overflow), 128'd0);
      check("short_f2", 128'(short_frame), 128'd0);

      // Back-pressure: wr_ready alternates 1,0,1,0.
      do_reset();
      ready_mode = 1'b1;
      push_words(16'h0300, 0, 8);
      push_addrs(BASE0, 4);
      send_frame(16'h0300, 64, -1, 1'b1);
      wait_fd(1, 400);
      wait_idle(100);
      check("overflow_tog", 128'(overflow), 128'd0);

      // Ack withheld for 40 pixel cycles: word 4 is dropped, later bursts keep their addresses.
      do_reset();
      ack_block = 1'b1;
      push_words(16'h0000, 0, 4);
      push_words(16'h0000, 5, 7);
      push_addrs(BASE0, 3);
      send_frame(16'h0000, 64, 40, 1'b1);
      wait_idle(200);
      repeat (20) @(negedge video_clk);
      check("overflow_set", 128'(overflow), 128'd1);
      check("ovf_no_frame_done", 128'(fd_count), 128'd0);
      check("ovf_short", 128'(short_frame), 128'd0);

      // Restart after 24 pixels: the third word is flushed and the frame restarts at BASE0.
      do_reset();
      push_words(16'h0000, 0, 2);
      push_addrs(BASE0, 1);
      send_frame(16'h0000, 24, -1, 1'b1);
      repeat (8) @(negedge video_clk);
      wait_idle(50);
      check("short_before", 128'(short_frame), 128'd0);
      push_words(16'h0200, 0, 8);
      push_addrs(BASE0, 4);
      send_frame(16'h0200, 64, -1, 1'b1);
      check("short_set", 128'(short_frame), 128'd1);
      wait_fd(1, 300);
      wait_idle(100);
      check("short_disp_buf", 128'(disp_buf), 128'd0);
      check("short_overflow", 128'(overflow), 128'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/fb_writer.md
Name: fb_writer

Overview:
- Downstream neighbour of align; sits in the video_clk domain.
- Consumes the aligned 16-bit pixel stream (data_aligned, data_aligned_valid, data_aligned_vs) and packs 8 pixels into 128-bit memory words.
- Buffers packed words in a small FIFO and writes them to external frame memory as fixed-length bursts.
- Double-buffers frames and reports which buffer holds the last complete frame for the scan-out reader.

Parameters:
- H_DISP, 1280, active pixels per line.
- V_DISP, 720, active lines per frame.
- BURST, 64, 128-bit beats per burst.
- FIFO_DEPTH, 128, packed-word FIFO depth; power of 2, at least 2*BURST.
- ADDR_W, 28, byte address width.
- BASE0, 28'h0000000, byte base address of frame buffer 0.
- BASE1, 28'h0200000, byte base address of frame buffer 1.

Ports:
- video_clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- data_aligned  in  16  pixel, RGB565.
- data_aligned_valid  in  1  pixel qualifier.
- data_aligned_vs  in  1  frame marker; rising edge = frame start.
- wr_req  out  1  burst request; held until acked.
- wr_ack  in  1  controller accepts request.
- wr_addr  out  ADDR_W  burst byte address; stable while wr_req is high.
- wr_data  out  128  beat data; pixel 0 in bits [15:0].
- wr_valid  out  1  beat valid.
- wr_ready  in  1  beat accepted when wr_valid && wr_ready.
- wr_last  out  1  final beat of a burst.
- disp_buf  out  1  index of the last fully written buffer.
- frame_done  out  1  one-cycle pulse when a frame completes.
- overflow  out  1  sticky: FIFO-full drop occurred.
- short_frame  out  1  sticky: a frame restarted before completion.

Behaviour:
- Reset: all outputs 0. Packer, FIFO, counters and FSM cleared. wr_buf=0, disp_buf=0.
- Clock/reset: one clock, video_clk; reset is synchronous and active-high (rst).
- Constants: FRAME_WORDS = H_DISP*V_DISP/8. FRAME_BURSTS = FRAME_WORDS/BURST, which must be an integer. BURST_BYTES = BURST*16.
- Frame sync:
  - Register data_aligned_vs; a rising edge is a frame start (sof).
  - On sof: clear the packer lane counter, pixel word count and burst count.
  - On sof with words written != 0 and frame incomplete: set short_frame, flush FIFO, abort any pending burst, keep wr_buf.
  - An abort during DATA is allowed only between beats; the FSM returns to IDLE after the current handshake.
- Packer:
  - Each valid pixel fills lane 0..7.
  - On lane 7, push the 128-bit word into the FIFO the next cycle.
  - Pixels arriving before the first sof are ignored.
  - Pixels beyond FRAME_WORDS*8 in one frame are ignored.
- FIFO:
  - Synchronous, FIFO_DEPTH x 128, registered read with one-cycle latency.
  - A push while full drops the word and sets overflow; the word counter still advances, so addressing stays frame-aligned.
- Burst FSM:
  - IDLE -> REQ when FIFO count >= BURST and bursts_issued < FRAME_BURSTS.
  - REQ: wr_req=1, wr_addr = (wr_buf ? BASE1 : BASE0) + bursts_issued*BURST_BYTES. On wr_ack -> DATA.
  - DATA: stream BURST beats from the FIFO. wr_valid is held until wr_ready. wr_data is stable while stalled. wr_last is high on beat BURST-1.
  - After the last handshake: bursts_issued++, -> IDLE. If bursts_issued reaches FRAME_BURSTS, go to DONE instead.
  - DONE: pulse frame_done, set disp_buf=wr_buf, toggle wr_buf, -> IDLE.
  - wr_req and wr_valid are never high together.
- Simultaneous events:
  - sof with a FIFO push in the same cycle: sof wins and the push is dropped without setting overflow.
  - wr_ack arriving in the same cycle wr_req rises is legal.
- Reset mid-burst: outputs drop to 0 next cycle. The controller must tolerate a truncated burst.

Decomposition:
- Package fb_pkg holds PIX_W=16, MEM_W=128, LANES=8, FSM state enum {IDLE, REQ, DATA, DONE}, and the frame_words/burst_bytes functions.
- One sub-module: fb_fifo (sync FIFO with count, full, empty).

Test Plan:
- Bench parameters: H_DISP=16, V_DISP=4, BURST=2, FIFO_DEPTH=4. This gives 8 words and 4 bursts per frame.
- Reset: rst high 3 cycles -> all outputs 0, disp_buf=0.
- Full frame, wr_ready=1, ack after 2 cycles, pixels 0..63 -> bursts at addrs 0x00, 0x20, 0x40, 0x60; first beat data = {16'h7..16'h0}; frame_done pulse; disp_buf=0, next frame writes at BASE1.
- wr_ready toggling 1010 -> wr_data stable during stalls, wr_last only on the 2nd beat, 4 bursts total.
- wr_ack held low for 40 cycles while pixels stream -> 5th word is dropped, overflow=1, later addresses unchanged.
- sof after 24 pixels -> short_frame=1, FIFO emptied, next burst at BASE0+0x00.
- Two complete frames -> disp_buf goes 0 then 1, frame_done pulses exactly twice.
